result_packer: RTL and testbench

Downstream stage between the core result path and the AXI-Stream master port. It accepts 32-bit result words one per handshake and packs word pairs into 64-bit stream beats. Beats are buffered in a FIFO and driven out as a framed stream, with `m_tlast` on the final beat of each frame. This isolates result production from `M_AXIS_TREADY` backpressure.

---
 rtl/result_packer.sv | 204 ++++++++++++++++++++
 tb/tb_result_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// result_packer: packs 32-bit result words in pairs into 64-bit framed AXI-Stream beats.
// Latency: a completed pair (or the lone last word of an odd frame) is visible on m_tvalid one cycle after acceptance.
// Backpressure: beats queue in a FIFO; res_ready drops when the FIFO is full, so m_tready stalls never lose data.

// Small synchronous FIFO with first-word-fall-through read and an occupancy count.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: pushes at full and pops at empty are ignored; the owner gates them with count.
module result_packer_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Room is checked before writing; reading needs at least one entry.
  assign do_push  = push && (count != FULL_CNT);
  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module result_packer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frame_words,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic        m_tvalid,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tstrb,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PACK  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [15:0]   words_left;
  logic          half;
  logic [31:0]   pack_lo;

  logic [CW-1:0] fifo_count;
  logic [64:0]   fifo_head;
  logic [64:0]   push_dat;
  logic          accept;
  logic          last_word;
  logic          push;
  logic          pop;
  logic          frame_go;
  logic          last_hs;

  // Input side: accept only while packing, with FIFO room and words still owed.
  assign res_ready = (state == S_PACK) && (fifo_count != FULL_CNT) && (words_left != 16'd0);
  assign accept    = res_valid & res_ready;
  assign last_word = (words_left == 16'd1);

  // A beat leaves the pack register when its upper half arrives or the frame ends early.
  assign push     = accept & (half | last_word);
  assign push_dat = {last_word,
                     (half ? res_data : 32'h0),
                     (half ? pack_lo  : res_data)};

  // Start is only honoured from IDLE with a non-empty frame.
  assign frame_go = (state == S_IDLE) && start && (frame_words != 16'd0);

  // Output side: head of the FIFO, zeroed when nothing is valid.
  assign m_tvalid = (fifo_count != '0);
  assign pop      = m_tvalid & m_tready;
  assign m_tdata  = m_tvalid ? fifo_head[63:0] : 64'h0;
  assign m_tlast  = m_tvalid & fifo_head[64];
  assign m_tstrb  = 8'hff;
  assign last_hs  = pop & fifo_head[64];

  assign busy = (state != S_IDLE);

  result_packer_fifo #(
    .WIDTH (65),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  // Frame sequencing: IDLE -> PACK while words arrive -> DRAIN until the last beat leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      words_left <= 16'd0;
      half       <= 1'b0;
      pack_lo    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            words_left <= frame_words;
            half       <= 1'b0;
            state      <= S_PACK;
          end
        end
        S_PACK: begin
          if (accept) begin
            words_left <= words_left - 16'd1;
            if (!half) begin
              pack_lo <= res_data;
            end
            if (last_word) begin
              half  <= 1'b0;
              state <= S_DRAIN;
            end else begin
              half <= ~half;
            end
          end
        end
        S_DRAIN: begin
          if (last_hs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion pulse one cycle after the frame's last beat is handshaked.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= last_hs && (state == S_DRAIN);
    end
  end

  // Sticky violation flag: a word offered while not accepted; a new frame clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (err & ~frame_go) | (res_valid & ~res_ready);
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: frames of known words, expected beats derived from the word list.
// A background compare process checks every handshaked beat, output gating, stall stability and done/busy.
// Literal beat values checked after each frame pin the model itself.
module tb_result_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] frame_words;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passed = 0;

  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  logic [31:0] wbuf[$];
  logic        stop_bp;
  int          sent;

  always #5 clk = ~clk;

  result_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_words (frame_words),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tstrb     (m_tstrb),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Expected beats of a frame: consecutive word pairs, low word first, odd tail padded with zero.
  task automatic load_frame_model();
    logic [31:0] hi;
    for (int i = 0; i < wbuf.size(); i += 2) begin
      hi = (i + 1 < wbuf.size()) ? wbuf[i+1] : 32'h0;
      exp_q.push_back({(i + 2 >= wbuf.size()), hi, wbuf[i]});
    end
  endtask

  task automatic fill_words(input int n, input logic [31:0] base);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back(base + 32'(i));
  endtask

  task automatic start_frame(input int n);
    load_frame_model();
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    frame_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer words only in cycles where res_ready is seen high, so no violation is ever caused.
  task automatic send_range(input int from, input int to, input int limit, output int cnt);
    int w;
    cnt = 0;
    for (int i = from; i < to; i++) begin
      w = 0;
      @(negedge clk);
      while (!res_ready && w < limit) begin
        @(negedge clk);
        w++;
      end
      if (!res_ready) return;
      res_valid = 1'b1;
      res_data  = wbuf[i];
      @(posedge clk); #1;
      res_valid = 1'b0;
      cnt++;
    end
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < limit);
    check("done_seen", done, 1);
  endtask

  // Continuous compare against the beat model, sampled on the falling edge.
  initial begin : compare
    logic        prev_stall;
    logic        last_hs_prev;
    logic [64:0] prev_beat;
    prev_stall   = 1'b0;
    last_hs_prev = 1'b0;
    prev_beat    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall   = 1'b0;
        last_hs_prev = 1'b0;
      end else begin
        check("tstrb", m_tstrb, 8'hff);
        if (!m_tvalid) check("gated_beat", {m_tlast, m_tdata}, 65'h0);
        if (prev_stall) check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
        check("done_pulse", done, last_hs_prev);
        if (last_hs_prev) check("busy_at_done", busy, 0);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {m_tlast, m_tdata}, 65'h0);
          end else begin
            check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
          end
          got_q.push_back({m_tlast, m_tdata});
        end
        last_hs_prev = m_tvalid & m_tready & m_tlast;
        prev_stall   = m_tvalid & ~m_tready;
        prev_beat    = {m_tlast, m_tdata};
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; start = 1'b0; frame_words = 16'd0;
    res_valid = 1'b0; res_data = 32'h0; m_tready = 1'b0; stop_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_ready", res_ready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Zero-length start is ignored
    @(posedge clk); #1;
    start = 1'b1; frame_words = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_start_busy", busy, 0);
    check("zero_start_ready", res_ready, 0);

    // Even frame, no backpressure; a start mid-frame must be ignored
    m_tready = 1'b1;
    fill_words(8, 32'd1);
    start_frame(8);
    @(negedge clk);
    check("even_busy", busy, 1);
    send_range(0, 4, 20, sent);
    check("even_sent_a", sent, 4);
    start = 1'b1; frame_words = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send_range(4, 8, 20, sent);
    check("even_sent_b", sent, 4);
    wait_done(100);
    check("even_nbeats", got_q.size(), 4);
    check("even_b0", got_q[0], 65'h0_00000002_00000001);
    check("even_b1", got_q[1], 65'h0_00000004_00000003);
    check("even_b2", got_q[2], 65'h0_00000006_00000005);
    check("even_b3", got_q[3], 65'h1_00000008_00000007);
    check("even_err", err, 0);

    // Odd frame
    wbuf.delete();
    wbuf.push_back(32'hA); wbuf.push_back(32'hB); wbuf.push_back(32'hC);
    start_frame(3);
    send_range(0, 3, 20, sent);
    check("odd_sent", sent, 3);
    wait_done(100);
    check("odd_nbeats", got_q.size(), 2);
    check("odd_b0", got_q[0], 65'h0_0000000B_0000000A);
    check("odd_b1", got_q[1], 65'h1_00000000_0000000C);

    // Full FIFO under total backpressure
    m_tready = 1'b0;
    fill_words(16, 32'd1);
    start_frame(16);
    send_range(0, 16, 10, sent);
    check("full_sent", sent, 8);
    check("full_ready_low", res_ready, 0);
    check("full_head", {m_tvalid, m_tlast, m_tdata}, {1'b1, 65'h0_00000002_00000001});
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    check("full_ready_before_pop", res_ready, 0);
    @(negedge clk);
    check("full_ready_after_pop", res_ready, 1);
    send_range(8, 16, 10, sent);
    check("full_sent_rest", sent, 8);
    wait_done(100);
    check("full_nbeats", got_q.size(), 8);
    check("full_b7", got_q[7], 65'h1_00000010_0000000F);
    check("full_err", err, 0);

    // Random backpressure over a 100-word frame
    fill_words(100, 32'h1000);
    start_frame(100);
    stop_bp = 1'b0;
    fork
      begin
        send_range(0, 100, 50, sent);
        wait_done(1000);
        stop_bp = 1'b1;
      end
      begin
        while (!stop_bp) begin
          @(posedge clk); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    check("rand_sent", sent, 100);
    check("rand_nbeats", got_q.size(), 50);
    check("rand_left", exp_q.size(), 0);
    check("rand_b49", got_q[49], 65'h1_00001063_00001062);

    // Protocol violation in IDLE
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = 32'hDEAD;
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    check("viol_err", err, 1);
    check("viol_tvalid", m_tvalid, 0);
    repeat (3) @(negedge clk);
    check("viol_tvalid_later", m_tvalid, 0);
    check("viol_err_sticky", err, 1);
    wbuf.delete();
    wbuf.push_back(32'h5); wbuf.push_back(32'h6);
    start_frame(2);
    @(negedge clk);
    check("viol_err_cleared", err, 0);
    send_range(0, 2, 20, sent);
    wait_done(100);
    check("viol_b0", got_q[0], 65'h1_00000006_00000005);

    // Reset mid-frame
    m_tready = 1'b0;
    fill_words(8, 32'd1);
    start_frame(8);
    send_range(0, 5, 20, sent);
    check("rstmid_sent", sent, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    check("rstmid_tvalid", m_tvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_err", err, 0);
    check("rstmid_ready", res_ready, 0);
    check("rstmid_done", done, 0);
    m_tready = 1'b1;
    fill_words(2, 32'd1);
    start_frame(2);
    send_range(0, 2, 20, sent);
    wait_done(100);
    check("rstmid_nbeats", got_q.size(), 1);
    check("rstmid_b0", got_q[0], 65'h1_00000002_00000001);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
